// File: rtl/denise_pkg.sv
// -----------------------------------------------------------------------------
// denise_pkg
// Shared constants and types for the Denise sprite engine:
//   HSTART_W        width of the horizontal counter and sprite start position
//   regKind_t       register kind carried in the low two REG_ADDR bits
//   CTL_ATTACH_BIT  CTL bit of an odd channel that attaches it to its even mate
//   CTL_H0_BIT      CTL bit holding hstart[0]
//   colorWidth()    width of the sprite colour index for a given channel count
// -----------------------------------------------------------------------------
package denise_pkg;

  localparam int HSTART_W       = 9;
  localparam int CTL_ATTACH_BIT = 7;
  localparam int CTL_H0_BIT     = 0;

  typedef enum logic [1:0] {
    REG_POS  = 2'd0,
    REG_CTL  = 2'd1,
    REG_DATA = 2'd2,
    REG_DATB = 2'd3
  } regKind_t;

  // Group index bits plus the two pixel bits of a channel.
  function automatic int colorWidth(input int numSpr);
    return $clog2(numSpr) + 1;
  endfunction

endpackage

// File: rtl/denise_spr_engine_if.sv
// -----------------------------------------------------------------------------
// denise_spr_engine_if
// Pixel-strobe, register-write and sprite-output bundle of the sprite engine.
//   PIX_EN     lowres pixel strobe          LINE_STB   line start
//   REG_WE     register write strobe        REG_ADDR   {channel, kind}
//   REG_WDATA  register write data          SPR_COLOR  winning colour index
//   SPR_VALID  non-transparent pixel        SPR_GRP    per-group non-zero flags
//   SPR_CLX    per-channel non-zero flags
// master: the bus/timing side driving the engine; slave: the engine itself.
// -----------------------------------------------------------------------------
interface denise_spr_engine_if #(
  parameter int NUM_SPR = 8,
  parameter int DATA_W  = 16
) ();
  import denise_pkg::*;

  localparam int ADDR_W  = $clog2(NUM_SPR) + 2;
  localparam int COLOR_W = colorWidth(NUM_SPR);

  logic               PIX_EN;
  logic               LINE_STB;
  logic               REG_WE;
  logic [ADDR_W-1:0]  REG_ADDR;
  logic [DATA_W-1:0]  REG_WDATA;
  logic [COLOR_W-1:0] SPR_COLOR;
  logic               SPR_VALID;
  logic [NUM_SPR/2-1:0] SPR_GRP;
  logic [NUM_SPR-1:0] SPR_CLX;

  modport master (
    output PIX_EN, LINE_STB, REG_WE, REG_ADDR, REG_WDATA,
    input  SPR_COLOR, SPR_VALID, SPR_GRP, SPR_CLX
  );

  modport slave (
    input  PIX_EN, LINE_STB, REG_WE, REG_ADDR, REG_WDATA,
    output SPR_COLOR, SPR_VALID, SPR_GRP, SPR_CLX
  );

endinterface

// File: rtl/denise_spr_chan.sv
// -----------------------------------------------------------------------------
// denise_spr_chan
// One hardware sprite channel: POS/CTL/DATA/DATB registers, armed flag,
// horizontal-start comparator and the A/B shifters.
//   clk, rst  clock and synchronous active-high reset
//   pixEn     pixel strobe          hcount  current horizontal position
//   we        write to this channel kind    register kind    wdata  write data
//   pixA/B    current pixel bits    attach  CTL attach bit (DENISE_SPR_ATTACH_EN)
// -----------------------------------------------------------------------------
module denise_spr_chan
  import denise_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                pixEn,
  input  logic [HSTART_W-1:0] hcount,
  input  logic                we,
  input  regKind_t            kind,
  input  logic [DATA_W-1:0]   wdata,
  output logic                pixA,
  output logic                pixB,
  output logic                attach
);

  logic [7:0]          posReg;
  logic                ctlH0;
  logic [DATA_W-1:0]   dataReg, datbReg;
  logic [DATA_W-1:0]   shiftA, shiftB;
  logic                armed;
  logic [HSTART_W-1:0] hstart;
  logic                match;

  assign hstart = {posReg, ctlH0};
  // Uses the register state from before any write landing on this same edge.
  assign match  = pixEn && armed && (hcount == hstart);
  assign pixA   = shiftA[DATA_W-1];
  assign pixB   = shiftB[DATA_W-1];

  // NOTE: state updates use non-blocking assignments so every flop samples
  // pre-edge values; the load below therefore sees the old DATA even when a
  // DATA write happens on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the data registers are plain flops, not a RAM, so they take the
      // reset like everything else and a freshly reset channel stays blank.
      posReg  <= '0;
      ctlH0   <= 1'b0;
      dataReg <= '0;
      datbReg <= '0;
      shiftA  <= '0;
      shiftB  <= '0;
      armed   <= 1'b0;
    end else begin
      // A match restarts the sprite even if it is still shifting out.
      if (match) begin
        shiftA <= dataReg;
        shiftB <= datbReg;
      end else if (pixEn) begin
        shiftA <= {shiftA[DATA_W-2:0], 1'b0};
        shiftB <= {shiftB[DATA_W-2:0], 1'b0};
      end
      if (we) begin
        case (kind)
          REG_POS:  posReg <= wdata[7:0];
          REG_CTL: begin
            ctlH0 <= wdata[CTL_H0_BIT];
            armed <= 1'b0;
          end
          REG_DATA: begin
            dataReg <= wdata;
            armed   <= 1'b1;
          end
          REG_DATB: datbReg <= wdata;
        endcase
      end
    end
  end

`ifdef DENISE_SPR_ATTACH_EN
  logic ctlAttach;
  always_ff @(posedge clk) begin
    if (rst) ctlAttach <= 1'b0;
    else if (we && kind == REG_CTL) ctlAttach <= wdata[CTL_ATTACH_BIT];
  end
  assign attach = ctlAttach;
`else
  assign attach = 1'b0;
`endif

endmodule

// File: rtl/denise_spr_engine.sv
// -----------------------------------------------------------------------------
// denise_spr_engine
// Sprite serialiser and priority resolver: NUM_SPR channels, a 9-bit
// horizontal counter and the group/attached-pair colour resolver.
//   C14M  system clock             RST  synchronous active-high reset
//   bus   denise_spr_engine_if.slave (pixel/line strobes, register writes,
//         registered SPR_COLOR / SPR_VALID / SPR_GRP / SPR_CLX)
// Build option: define DENISE_SPR_ATTACH_EN to enable attached-pair colour;
// without it CTL[7] is ignored and every pair resolves in group mode.
// -----------------------------------------------------------------------------
module denise_spr_engine
  import denise_pkg::*;
#(
  parameter int NUM_SPR = 8,
  parameter int DATA_W  = 16
) (
  input logic                C14M,
  input logic                RST,
  denise_spr_engine_if.slave bus
);

  localparam int CHAN_W  = $clog2(NUM_SPR);
  localparam int NUM_GRP = NUM_SPR / 2;
  localparam int GRP_W   = CHAN_W - 1;
  localparam int COLOR_W = colorWidth(NUM_SPR);

  logic [HSTART_W-1:0] hcount;
  logic [CHAN_W-1:0]   regChan;
  regKind_t            regKind;
  logic [NUM_SPR-1:0]  pixA, pixB, chanAttach, clxNext;
  logic [NUM_GRP-1:0]  grpHit;
  logic [COLOR_W-1:0]  colorNext;
  logic [1:0]          evenP, oddP;

  assign regChan = bus.REG_ADDR[CHAN_W+1:2];
  assign regKind = regKind_t'(bus.REG_ADDR[1:0]);

  // LINE_STB wins over the increment; channels compare the pre-clear value.
  always_ff @(posedge C14M) begin
    if (RST)               hcount <= '0;
    else if (bus.LINE_STB) hcount <= '0;
    else if (bus.PIX_EN)   hcount <= hcount + HSTART_W'(1);
  end

  for (genvar i = 0; i < NUM_SPR; i++) begin : gChan
    denise_spr_chan #(.DATA_W(DATA_W)) uChan (
      .clk    (C14M),
      .rst    (RST),
      .pixEn  (bus.PIX_EN),
      .hcount (hcount),
      .we     (bus.REG_WE && (regChan == CHAN_W'(i))),
      .kind   (regKind),
      .wdata  (bus.REG_WDATA),
      .pixA   (pixA[i]),
      .pixB   (pixB[i]),
      .attach (chanAttach[i])
    );
  end

  assign clxNext = pixA | pixB;

  // Walk groups from highest to lowest so the lowest non-zero group is the
  // last writer of colorNext and therefore wins.
  always_comb begin
    // NOTE: every variable gets a default before the loop; otherwise a path
    // that skips an assignment would infer a latch.
    grpHit    = '0;
    colorNext = '0;
    evenP     = '0;
    oddP      = '0;
    for (int g = NUM_GRP - 1; g >= 0; g--) begin
      evenP     = {pixB[2*g], pixA[2*g]};
      oddP      = {pixB[2*g+1], pixA[2*g+1]};
      grpHit[g] = |{evenP, oddP};
      if (grpHit[g]) begin
        colorNext = {GRP_W'(g), (evenP != 2'b00) ? evenP : oddP};
`ifdef DENISE_SPR_ATTACH_EN
        // Attached pair forms one 4-bit colour {oddA, oddB, evenA, evenB}.
        if (chanAttach[2*g+1])
          colorNext = COLOR_W'({oddP[0], oddP[1], evenP[0], evenP[1]});
`endif
      end
    end
  end

`ifndef DENISE_SPR_ATTACH_EN
  logic unusedAttach;
  assign unusedAttach = &{1'b0, chanAttach};
`endif

  always_ff @(posedge C14M) begin
    if (RST) begin
      bus.SPR_COLOR <= '0;
      bus.SPR_VALID <= 1'b0;
      bus.SPR_GRP   <= '0;
      bus.SPR_CLX   <= '0;
    end else begin
      bus.SPR_COLOR <= colorNext;
      bus.SPR_VALID <= |grpHit;
      bus.SPR_GRP   <= grpHit;
      bus.SPR_CLX   <= clxNext;
    end
  end

endmodule
